// File: rtl/move_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer_if
//  Description : Bus bundle between the move sequencer and its neighbours:
//                command store read port, map read port, fog-of-war bitmap
//                set port and the display-writer request/acknowledge pair.
//  Ports       : master modport = sequencer side (drives strobes/addresses)
//                slave  modport = memory / display side (returns data/ack)
//  Revision    : 1.0  initial release
// ============================================================================
interface move_sequencer_if;
   // command store
   logic        cmd_rd;
   logic [15:0] cmd_addr;
   logic        cmd_valid;
   logic [15:0] cmd_data;
   // map array
   logic        map_rd;
   logic [6:0]  map_addr;
   logic [15:0] map_data;
   // reveal bitmap
   logic        reveal_we;
   logic [6:0]  reveal_addr;
   // display writer
   logic        disp_req;
   logic        disp_ack;

   modport master (
      output cmd_rd, cmd_addr,
      input  cmd_valid, cmd_data,
      output map_rd, map_addr,
      input  map_data,
      output reveal_we, reveal_addr,
      output disp_req,
      input  disp_ack
   );

   modport slave (
      input  cmd_rd, cmd_addr,
      output cmd_valid, cmd_data,
      input  map_rd, map_addr,
      output map_data,
      input  reveal_we, reveal_addr,
      input  disp_req,
      output disp_ack
   );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Sequenced controller for the 10x10 dungeon datapath. Fetches
//                a command, bounds-checks the move, reads the target map tile,
//                updates the player cell, sweeps the 12-cell fog-of-war reveal
//                pattern into the bitmap and hands off to the display writer.
//  Ports       : clk       system clock
//                rst_n     synchronous active-low reset
//                start     begin sequencing (honoured in IDLE only)
//                bus       master side of move_sequencer_if
//                pos       current player cell (registered)
//                eip       next command index (registered)
//                busy      high outside IDLE/HALT
//                bump      one-cycle pulse on a blocked move
//                at_exit   sticky, player stands on the exit tile
//  Revision    : 1.0  initial release
// ============================================================================
module move_sequencer #(
   parameter int unsigned START_POS = 50,
   parameter int unsigned WALL_CODE = 5,
   parameter int unsigned EXIT_CODE = 3
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          start,
   move_sequencer_if.master   bus,
   output logic [6:0]         pos,
   output logic [15:0]        eip,
   output logic               busy,
   output logic               bump,
   output logic               at_exit
);

   localparam logic [6:0]  c_start_pos = 7'(START_POS);
   localparam logic [15:0] c_wall_code = 16'(WALL_CODE);
   localparam logic [15:0] c_exit_code = 16'(EXIT_CODE);
   localparam logic [3:0]  c_last_idx  = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REVEAL   = 3'd1,
      S_DISPLAY  = 3'd2,
      S_FETCH    = 3'd3,
      S_CMD_WAIT = 3'd4,
      S_MAP_WAIT = 3'd5,
      S_MOVE     = 3'd6,
      S_HALT     = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_pos;
   logic [15:0] r_eip;
   logic [6:0]  r_target;
   logic [3:0]  r_idx;
   logic        r_bump;
   logic        r_at_exit;

   // decoded control from the next-state process
   logic        w_eip_inc;
   logic        w_latch_target;
   logic        w_pos_update;
   logic        w_set_exit;
   logic        w_bump_set;

   // grid coordinates of the current cell
   logic [3:0]  w_row;
   logic [3:0]  w_col;

   // command decode
   logic        w_is_move;
   logic        w_oob;
   logic [6:0]  w_target;

   // reveal sweep
   logic signed [4:0] w_dr;
   logic signed [4:0] w_dc;
   logic signed [4:0] w_nrow;
   logic signed [4:0] w_ncol;
   logic        w_reveal_ok;
   logic [6:0]  w_reveal_addr;

   assign w_row = 4'(r_pos / 7'd10);
   assign w_col = 4'(r_pos % 7'd10);

   // ------------------------------------------------------------------
   // Command decode: target cell and edge test for the command word
   // currently presented on cmd_data.
   // ------------------------------------------------------------------
   always_comb begin
      w_is_move = 1'b0;
      w_oob     = 1'b0;
      w_target  = r_pos;
      case (bus.cmd_data)
         16'd1: begin
            w_is_move = 1'b1;
            w_oob     = (w_col == 4'd9);
            w_target  = r_pos + 7'd1;
         end
         16'd2: begin
            w_is_move = 1'b1;
            w_oob     = (w_col == 4'd0);
            w_target  = r_pos - 7'd1;
         end
         16'd3: begin
            w_is_move = 1'b1;
            w_oob     = (w_row == 4'd0);
            w_target  = r_pos - 7'd10;
         end
         16'd4: begin
            w_is_move = 1'b1;
            w_oob     = (w_row == 4'd9);
            w_target  = r_pos + 7'd10;
         end
         default: begin
            w_is_move = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Reveal pattern as (row, col) deltas so that an offset which would
   // wrap into the neighbouring row is rejected rather than written.
   // Order: -20,-11,-10,-9,-2,-1,+1,+2,+9,+10,+11,+20
   // ------------------------------------------------------------------
   always_comb begin
      w_dr = 5'sd0;
      w_dc = 5'sd0;
      case (r_idx)
         4'd0:  begin w_dr = -5'sd2; w_dc =  5'sd0; end
         4'd1:  begin w_dr = -5'sd1; w_dc = -5'sd1; end
         4'd2:  begin w_dr = -5'sd1; w_dc =  5'sd0; end
         4'd3:  begin w_dr = -5'sd1; w_dc =  5'sd1; end
         4'd4:  begin w_dr =  5'sd0; w_dc = -5'sd2; end
         4'd5:  begin w_dr =  5'sd0; w_dc = -5'sd1; end
         4'd6:  begin w_dr =  5'sd0; w_dc =  5'sd1; end
         4'd7:  begin w_dr =  5'sd0; w_dc =  5'sd2; end
         4'd8:  begin w_dr =  5'sd1; w_dc = -5'sd1; end
         4'd9:  begin w_dr =  5'sd1; w_dc =  5'sd0; end
         4'd10: begin w_dr =  5'sd1; w_dc =  5'sd1; end
         4'd11: begin w_dr =  5'sd2; w_dc =  5'sd0; end
         default: begin w_dr = 5'sd0; w_dc = 5'sd0; end
      endcase
   end

   assign w_nrow        = $signed({1'b0, w_row}) + w_dr;
   assign w_ncol        = $signed({1'b0, w_col}) + w_dc;
   assign w_reveal_ok   = !w_nrow[4] && (w_nrow <= 5'sd9) &&
                          !w_ncol[4] && (w_ncol <= 5'sd9);
   assign w_reveal_addr = 7'(w_nrow[3:0]) * 7'd10 + 7'(w_ncol[3:0]);

   // ------------------------------------------------------------------
   // Next-state and strobe decode. Every strobe is a pure function of the
   // state, so at most one of them is ever high and reset drops them all
   // on the very next cycle.
   // ------------------------------------------------------------------
   always_comb begin
      w_next          = r_state;
      w_eip_inc       = 1'b0;
      w_latch_target  = 1'b0;
      w_pos_update    = 1'b0;
      w_set_exit      = 1'b0;
      w_bump_set      = 1'b0;
      bus.cmd_rd      = 1'b0;
      bus.map_rd      = 1'b0;
      bus.reveal_we   = 1'b0;
      bus.disp_req    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_REVEAL;
            end
         end

         S_REVEAL: begin
            bus.reveal_we = w_reveal_ok;
            if (r_idx == c_last_idx) begin
               w_next = S_DISPLAY;
            end
         end

         S_DISPLAY: begin
            bus.disp_req = 1'b1;
            if (bus.disp_ack) begin
               w_next = r_at_exit ? S_HALT : S_FETCH;
            end
         end

         S_FETCH: begin
            bus.cmd_rd = 1'b1;
            w_next     = S_CMD_WAIT;
         end

         S_CMD_WAIT: begin
            if (!bus.cmd_valid) begin
               // nothing queued yet: poll the same index again
               w_next = S_FETCH;
            end else begin
               w_eip_inc = 1'b1;
               if (!w_is_move) begin
                  w_next = S_REVEAL;
               end else if (w_oob) begin
                  w_bump_set = 1'b1;
                  w_next     = S_REVEAL;
               end else begin
                  w_latch_target = 1'b1;
                  w_next         = S_MAP_WAIT;
               end
            end
         end

         // The map read is issued from the latched target, so the tile
         // arrives in MOVE, one cycle after the strobe.
         S_MAP_WAIT: begin
            bus.map_rd = 1'b1;
            w_next     = S_MOVE;
         end

         S_MOVE: begin
            if (bus.map_data == c_wall_code) begin
               w_bump_set = 1'b1;
            end else begin
               w_pos_update = 1'b1;
               w_set_exit   = (bus.map_data == c_exit_code);
            end
            w_next = S_REVEAL;
         end

         S_HALT: begin
            w_next = S_HALT;
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pos     <= c_start_pos;
         r_eip     <= 16'd0;
         r_target  <= 7'd0;
         r_idx     <= 4'd0;
         r_bump    <= 1'b0;
         r_at_exit <= 1'b0;
      end else begin
         r_state <= w_next;
         r_bump  <= w_bump_set;
         if (w_eip_inc) begin
            r_eip <= r_eip + 16'd1;
         end
         if (w_latch_target) begin
            r_target <= w_target;
         end
         if (w_pos_update) begin
            r_pos <= r_target;
         end
         if (w_set_exit) begin
            r_at_exit <= 1'b1;
         end
         // sweep index runs 0..11 while in REVEAL and parks at 0 otherwise
         if (r_state == S_REVEAL && r_idx != c_last_idx) begin
            r_idx <= r_idx + 4'd1;
         end else begin
            r_idx <= 4'd0;
         end
      end
   end

   assign bus.cmd_addr    = r_eip;
   assign bus.map_addr    = r_target;
   assign bus.reveal_addr = w_reveal_addr;

   assign pos     = r_pos;
   assign eip     = r_eip;
   assign bump    = r_bump;
   assign at_exit = r_at_exit;
   assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Directed self-checking bench for move_sequencer. A negedge
//                responder models the command store, map array and display
//                writer and logs every strobe; one initial block walks the
//                directed steps and checks against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  pos;
   logic [15:0] eip;
   logic        busy;
   logic        bump;
   logic        at_exit;

   move_sequencer_if bus ();

   move_sequencer #(
      .START_POS (50),
      .WALL_CODE (5),
      .EXIT_CODE (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bus     (bus),
      .pos     (pos),
      .eip     (eip),
      .busy    (busy),
      .bump    (bump),
      .at_exit (at_exit)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // responder state / stimulus knobs
   logic [15:0] map_mem [0:127];
   int    cyc = 0;
   int    polls_left = 0;
   bit    cmd_pending = 0;
   int    cmd_code = 0;
   bit    cmd_hold = 0;
   int    ack_delay = 0;
   int    disp_wait = 0;
   int    disp_done = 0;
   int    disp_cnt = 0;
   int    first_disp_cyc = -1;
   int    bump_cnt = 0;
   string cmd_s = "";
   string map_s = "";
   string reveal_s = "";

   // Memory / display model: answers on the negedge of a strobe cycle and
   // holds the answer through the following cycle's sampling edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         bus.cmd_valid = 1'b0;
         bus.cmd_data  = 16'd0;
         bus.map_data  = 16'd0;
         bus.disp_ack  = 1'b0;
         cmd_hold      = 0;
         disp_wait     = 0;
      end else begin
         if (bus.cmd_rd) begin
            cmd_s    = {cmd_s, $sformatf("%0d ", bus.cmd_addr)};
            cmd_hold = 1;
            if (polls_left > 0) begin
               polls_left--;
               bus.cmd_valid = 1'b0;
            end else if (cmd_pending) begin
               bus.cmd_valid = 1'b1;
               bus.cmd_data  = 16'(cmd_code);
               cmd_pending   = 0;
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end else if (cmd_hold) begin
            cmd_hold = 0;
         end else begin
            bus.cmd_valid = 1'b0;
         end

         if (bus.map_rd) begin
            map_s        = {map_s, $sformatf("%0d ", bus.map_addr)};
            bus.map_data = map_mem[bus.map_addr];
         end

         if (bus.reveal_we) begin
            reveal_s = {reveal_s, $sformatf("%0d ", bus.reveal_addr)};
         end

         if (bump) begin
            bump_cnt++;
         end

         if (bus.disp_req) begin
            disp_cnt++;
            if (first_disp_cyc < 0) first_disp_cyc = cyc;
            bus.disp_ack = (disp_wait >= ack_delay);
            disp_wait++;
            if (bus.disp_ack) disp_done++;
         end else begin
            bus.disp_ack = 1'b0;
            disp_wait    = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_s(input string tag, input string obs, input string exp);
      n_tests++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
      end
   endtask

   // Wait for display completion number `want`, then for the next FETCH
   // (or for HALT when until_halt is set).
   task automatic wait_done(input string tag, input int want, input bit until_halt);
      bit hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         tick();
         if (disp_done >= want && (until_halt ? !busy : bus.cmd_rd)) hit = 1;
      end
      check({tag, "_timeout"}, 32'(hit), 32'd1);
   endtask

   task automatic clear_logs();
      cmd_s = ""; map_s = ""; reveal_s = "";
      bump_cnt = 0; disp_cnt = 0; first_disp_cyc = -1;
   endtask

   task automatic do_cmd(input string tag, input int code, input int polls,
                         input int delay, input bit until_halt);
      clear_logs();
      ack_delay   = delay;
      polls_left  = polls;
      cmd_code    = code;
      cmd_pending = 1;
      wait_done(tag, disp_done + 1, until_halt);
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 128; i++) map_mem[i] = 16'd0;
      map_mem[50] = 16'd5;   // wall
      map_mem[51] = 16'd4;   // plain floor
      map_mem[59] = 16'd3;   // exit

      // ---- reset state ----
      rst_n = 1'b0;
      start = 1'b0;
      tick(); tick();
      check("rst_pos",     32'(pos), 32'd50);
      check("rst_eip",     32'(eip), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_at_exit", 32'(at_exit), 32'd0);
      check("rst_bump",    32'(bump), 32'd0);
      check("rst_strobes", 32'({bus.cmd_rd, bus.map_rd, bus.reveal_we, bus.disp_req}), 32'd0);

      // ---- start: initial reveal around 50 (col 0 drops -11,-2,-1,+9) ----
      rst_n = 1'b1;
      clear_logs();
      c0 = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      wait_done("start", 1, 0);
      check_s("start_reveal", reveal_s, "30 40 41 51 52 60 61 70 ");
      check("start_disp_latency", 32'(first_disp_cyc - c0), 32'd13);
      check_s("start_no_map", map_s, "");

      // ---- cmd 1 right 50->51, display ack delayed by 3 cycles ----
      do_cmd("right", 1, 0, 3, 0);
      check_s("right_map", map_s, "51 ");
      check("right_pos", 32'(pos), 32'd51);
      check("right_eip", 32'(eip), 32'd1);
      check("right_bump", 32'(bump_cnt), 32'd0);
      check_s("right_reveal", reveal_s, "31 40 41 42 50 52 53 60 61 62 71 ");
      check("right_disp_cycles", 32'(disp_cnt), 32'd4);
      check_s("right_fetch", cmd_s, "0 1 ");

      // ---- cmd 2 left into wall at 50 ----
      do_cmd("wall", 2, 0, 0, 0);
      check_s("wall_map", map_s, "50 ");
      check("wall_bump", 32'(bump_cnt), 32'd1);
      check("wall_pos", 32'(pos), 32'd51);
      check("wall_eip", 32'(eip), 32'd2);
      check_s("wall_reveal", reveal_s, "31 40 41 42 50 52 53 60 61 62 71 ");
      check("wall_disp", 32'(disp_cnt), 32'd1);

      // ---- three empty polls, then cmd 3 up 51->41 ----
      do_cmd("poll", 3, 3, 0, 0);
      check_s("poll_fetch", cmd_s, "2 2 2 2 3 ");
      check_s("poll_map", map_s, "41 ");
      check("poll_pos", 32'(pos), 32'd41);
      check("poll_eip", 32'(eip), 32'd3);

      // ---- walk right to col 9, then push against the east edge ----
      for (int k = 0; k < 8; k++) do_cmd("walk", 1, 0, 0, 0);
      check("walk_pos", 32'(pos), 32'd49);
      check("walk_eip", 32'(eip), 32'd11);
      do_cmd("edge", 1, 0, 0, 0);
      check_s("edge_no_map", map_s, "");
      check("edge_bump", 32'(bump_cnt), 32'd1);
      check("edge_pos", 32'(pos), 32'd49);
      check("edge_eip", 32'(eip), 32'd12);
      check_s("edge_reveal", reveal_s, "29 38 39 47 48 58 59 69 ");

      // ---- unknown code is a no-op that still advances eip ----
      do_cmd("noop", 7, 0, 0, 0);
      check_s("noop_map", map_s, "");
      check("noop_bump", 32'(bump_cnt), 32'd0);
      check("noop_pos", 32'(pos), 32'd49);
      check("noop_eip", 32'(eip), 32'd13);
      check("noop_at_exit", 32'(at_exit), 32'd0);

      // ---- cmd 4 down onto the exit tile at 59 ----
      do_cmd("exit", 4, 0, 0, 1);
      check_s("exit_map", map_s, "59 ");
      check("exit_pos", 32'(pos), 32'd59);
      check("exit_at_exit", 32'(at_exit), 32'd1);
      check("exit_busy", 32'(busy), 32'd0);
      check("exit_eip", 32'(eip), 32'd14);

      // ---- HALT ignores start and queued commands ----
      clear_logs();
      cmd_pending = 1;
      cmd_code    = 1;
      start = 1'b1;
      repeat (4) tick();
      start = 1'b0;
      tick();
      check_s("halt_no_fetch", cmd_s, "");
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_pos", 32'(pos), 32'd59);
      cmd_pending = 0;

      // ---- reset in the middle of a reveal sweep ----
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("midrev_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      clear_logs();
      tick();
      check("midrev_busy", 32'(busy), 32'd0);
      check("midrev_pos", 32'(pos), 32'd50);
      check("midrev_eip", 32'(eip), 32'd0);
      check("midrev_at_exit", 32'(at_exit), 32'd0);
      check("midrev_reveal_we", 32'(bus.reveal_we), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check_s("midrev_no_reveal", reveal_s, "");
      check("midrev_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
